ysyx_24100005_register_file: RTL and testbench
==============================================

YSYX_24100005_REGISTER_FILE -- requirements
Module: ysyx_24100005_register_file

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5: register index width, giving 2^ADDR_WIDTH entries (32 by default).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of each register entry.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port wen, input, 1 bit: write enable for the write port.
REQ-006 SHALL have port waddr, input, ADDR_WIDTH bits: write index (the rd field).
REQ-007 SHALL have port wdata, input, DATA_WIDTH bits: write data.
REQ-008 SHALL have port rs1addr, input, ADDR_WIDTH bits: read port 1 index.
REQ-009 SHALL have port rs2addr, input, ADDR_WIDTH bits: read port 2 index.
REQ-010 SHALL have port rs1data, output, DATA_WIDTH bits: read port 1 data.
REQ-011 SHALL have port rs2data, output, DATA_WIDTH bits: read port 2 data.

Function
REQ-012 SHALL hold 2^ADDR_WIDTH entries of DATA_WIDTH bits; entry 0 is hardwired to zero.
REQ-013 SHALL write wdata into entry waddr on a rising clk edge when wen=1, rst=1 and waddr!=0.
REQ-014 SHALL ignore writes to entry 0; entry 0 never changes and always reads 0.
REQ-015 SHALL leave all entries unchanged on an edge where wen=0.
REQ-016 SHALL drive rs1data/rs2data combinationally (zero-cycle latency) from entries rs1addr/rs2addr.
REQ-017 SHALL not bypass writes: a read of waddr in the write cycle returns the old value; the new value is visible immediately after the edge.
REQ-018 SHALL allow both read ports to address the same entry, or the write entry, with no conflict; both return the same stored value.
REQ-019 SHALL treat X/unknown address bits as unspecified; the bench drives only known addresses.
REQ-020 SHALL have no handshake; a write completes in exactly one edge, with no stall or busy output.

Reset
REQ-021 SHALL clear every entry to 0 immediately when rst falls, without waiting for a clk edge.
REQ-022 SHALL hold every entry at 0 while rst=0; writes with wen=1 are discarded, and reset has priority over a coincident write edge.
REQ-023 SHALL keep read ports combinational during reset, returning 0 for every address.
REQ-024 SHALL accept writes again from the first rising clk edge after rst returns to 1.

Verification
REQ-025 Reset: rst=0 mid-cycle after entries hold nonzero data -> rs1data=rs2data=0 for rs1addr=5 and rs2addr=31 before the next clk edge.
REQ-026 Write/read: wen=1, waddr=3, wdata=0xDEADBEEF, then edge -> rs1addr=3 gives 0xDEADBEEF; in the same cycle before the edge, rs1data gave the old value 0.
REQ-027 x0: wen=1, waddr=0, wdata=0xFFFFFFFF, then edge -> rs1addr=0 and rs2addr=0 both read 0x00000000.
REQ-028 Dual read: write 0x11 to entry 1 and 0x22 to entry 31 -> rs1addr=31 gives 0x22 and rs2addr=1 gives 0x11 simultaneously; both ports at 31 give 0x22.
REQ-029 Write disable: wen=0, waddr=7, wdata=0x12345678, then edge -> entry 7 keeps its prior value 0xA5A5A5A5.
REQ-030 Reset during write: rst=0 asserted with wen=1, waddr=4, wdata=0x55 on the edge -> entry 4 reads 0 after the edge; after rst=1, the next write of 0x55 succeeds.

Source files
------------

// File: rtl/ysyx_24100005_register_file.sv
`default_nettype none
// ============================================================================
// ysyx_24100005_register_file : 2R1W register file, entry 0 hardwired to zero
// Revision 1.0
// ============================================================================
module ysyx_24100005_register_file #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wen,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] rs1addr,
   input  logic [ADDR_WIDTH-1:0] rs2addr,
   output logic [DATA_WIDTH-1:0] rs1data,
   output logic [DATA_WIDTH-1:0] rs2data
);

   localparam int c_depth = 1 << ADDR_WIDTH;

   // Entry 0 has no storage; only entries 1..DEPTH-1 are flops.
   logic [DATA_WIDTH-1:0] regs_q [1:c_depth-1];
   logic [DATA_WIDTH-1:0] regs_d [1:c_depth-1];

   always_comb begin
      for (int i = 1; i < c_depth; i++) begin
         regs_d[i] = (wen && (waddr == ADDR_WIDTH'(i))) ? wdata : regs_q[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 1; i < c_depth; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 1; i < c_depth; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // No write bypass: reads see the stored value only.
   always_comb begin
      rs1data = '0;
      rs2data = '0;
      if (rs1addr != '0) rs1data = regs_q[rs1addr];
      if (rs2addr != '0) rs2data = regs_q[rs2addr];
   end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100005_register_file.sv
`default_nettype none
// Directed and randomized checks of the register file against an array model.
module tb_ysyx_24100005_register_file;

   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          wen;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic [AW-1:0] rs1addr;
   logic [AW-1:0] rs2addr;
   logic [DW-1:0] rs1data;
   logic [DW-1:0] rs2data;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] model [32];

   ysyx_24100005_register_file #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
      .rs1addr(rs1addr), .rs2addr(rs2addr), .rs1data(rs1data), .rs2data(rs2data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reads(input string tag);
      check({tag, "_rs1"}, rs1data, model[rs1addr]);
      check({tag, "_rs2"}, rs2data, model[rs2addr]);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model[i] = '0;
   endtask

   // Advance one rising edge and apply the architectural write rule to the model.
   task automatic edge_step();
      @(posedge clk);
      if (rst && wen && waddr != 0) model[waddr] = wdata;
      #1;
   endtask

   task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wen = 1'b1; waddr = a; wdata = d;
      edge_step();
      wen = 1'b0;
   endtask

   initial begin
      model_clear();
      rst = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; rs1addr = 5'd5; rs2addr = 5'd31;
      #2;
      check("reset_init", rs1data | rs2data, 32'h0);
      @(posedge clk); #3;
      rst = 1'b1;
      @(posedge clk); #1;

      // Write/read with no bypass
      wen = 1'b1; waddr = 5'd3; wdata = 32'hDEADBEEF; rs1addr = 5'd3;
      #1;
      check("wr3_before_edge", rs1data, 32'h0);
      edge_step();
      wen = 1'b0;
      check("wr3_after_edge", rs1data, 32'hDEADBEEF);

      // Entry 0 ignores writes
      write_reg(5'd0, 32'hFFFFFFFF);
      rs1addr = 5'd0; rs2addr = 5'd0; #1;
      check("x0_rs1", rs1data, 32'h0);
      check("x0_rs2", rs2data, 32'h0);

      // Dual read
      write_reg(5'd1, 32'h11);
      write_reg(5'd31, 32'h22);
      rs1addr = 5'd31; rs2addr = 5'd1; #1;
      check("dual_rs1_31", rs1data, 32'h22);
      check("dual_rs2_1", rs2data, 32'h11);
      rs2addr = 5'd31; #1;
      check("same_rs1_31", rs1data, 32'h22);
      check("same_rs2_31", rs2data, 32'h22);

      // Write disable
      write_reg(5'd7, 32'hA5A5A5A5);
      wen = 1'b0; waddr = 5'd7; wdata = 32'h12345678;
      edge_step();
      rs1addr = 5'd7; #1;
      check("wen0_keep7", rs1data, 32'hA5A5A5A5);

      // Randomized traffic, reads checked both before and after each edge
      for (int n = 0; n < 300; n++) begin
         wen     = 1'($urandom_range(0, 3) != 0);
         waddr   = AW'($urandom_range(0, 31));
         wdata   = $urandom;
         rs1addr = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, 31));
         rs2addr = ($urandom_range(0, 3) == 0) ? rs1addr : AW'($urandom_range(0, 31));
         #1;
         check_reads("rand_pre");
         edge_step();
         check_reads("rand_post");
      end
      wen = 1'b0;

      // Asynchronous reset mid-cycle with live data in 5 and 31
      write_reg(5'd5, 32'hCAFEF00D);
      write_reg(5'd31, 32'h0BADF00D);
      rs1addr = 5'd5; rs2addr = 5'd31; #1;
      check("pre_rst_5", rs1data, 32'hCAFEF00D);
      #1;
      rst = 1'b0; model_clear(); #1;
      check("async_rst_5", rs1data, 32'h0);
      check("async_rst_31", rs2data, 32'h0);

      // Writes discarded while held in reset
      for (int n = 0; n < 4; n++) begin
         wen = 1'b1; waddr = AW'($urandom_range(1, 31)); wdata = $urandom | 32'h1;
         rs1addr = waddr; rs2addr = AW'($urandom_range(0, 31));
         edge_step();
         check_reads("in_rst");
      end
      wen = 1'b0;
      #2; rst = 1'b1;
      @(posedge clk); #1;

      // Reset coinciding with a write edge
      wen = 1'b1; waddr = 5'd4; wdata = 32'h55; rs1addr = 5'd4;
      #1; rst = 1'b0;
      edge_step();
      check("rst_write_4", rs1data, 32'h0);
      #2; rst = 1'b1;
      edge_step();
      wen = 1'b0;
      check("post_rst_write_4", rs1data, 32'h55);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
